// File: rtl/adc_dac_pkg.sv
// Shared types and constants for the XADC -> AD5626 sample sequencer.
package adc_dac_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int MIN_DIV    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CONVERT,
        ST_WAIT_DAC,
        ST_WRITE
    } seq_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Programmable period counter: one-cycle tick every eff_div cycles while enabled.
module sample_tick_gen
    import adc_dac_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] limit;

    // The period is sampled at count 0, so a new div only applies from the next wrap.
    always_comb begin
        div_eff = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;
        limit   = (cnt_q == '0) ? div_eff : per_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        tick_o  = 1'b0;
        if (!enable_i) begin
            cnt_d = '0;
        end else begin
            if (cnt_q == '0) begin
                per_d = div_eff;
            end
            if (cnt_q == limit - DIV_W'(1)) begin
                tick_o = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            per_q <= DIV_W'(MIN_DIV);
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/adc_dac_sequencer.sv
// Sample-rate scheduler: strobes the XADC each period, then forwards the result to
// the AD5626 encoder once it is idle. Tracks overrun, timeout and written samples.
module adc_dac_sequencer
    import adc_dac_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DIV_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div,
    input  logic              clr_status,
    output logic              convst,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              dac_busy,
    output logic              dac_set,
    output logic [DATA_W-1:0] dac_data,
    output logic [15:0]       sample_count,
    output logic              overrun,
    output logic              timeout,
    output seq_state_t        state_dbg
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    seq_state_t        state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              ovr_q, ovr_d;
    logic              tmo_q, tmo_d;
    logic              tick;
    logic              inc;
    logic              tmo_set;
    logic              ovr_set;

    sample_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable),
        .div_i    (div),
        .tick_o   (tick)
    );

    // adc_valid is a one-cycle qualifier for adc_data, honoured only in CONVERT;
    // dac_busy is a level that blocks the write strobe, there is no ack back.
    always_comb begin
        state_d = state_q;
        to_d    = '0;
        data_d  = data_q;
        inc     = 1'b0;
        tmo_set = 1'b0;
        ovr_set = tick && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:     if (tick) state_d = ST_START;
            ST_START:    state_d = ST_CONVERT;
            ST_CONVERT: begin
                if (adc_valid) begin
                    data_d  = adc_data;
                    state_d = ST_WAIT_DAC;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_WAIT_DAC: if (!dac_busy) state_d = ST_WRITE;
            ST_WRITE: begin
                inc     = 1'b1;
                state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase

        // A set or increment coinciding with a clear takes precedence over it.
        if (clr_status) begin
            cnt_d = inc ? 16'd1 : 16'd0;
        end else begin
            cnt_d = inc ? cnt_q + 16'd1 : cnt_q;
        end
        ovr_d = ovr_set | (ovr_q & ~clr_status);
        tmo_d = tmo_set | (tmo_q & ~clr_status);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            to_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign convst       = (state_q == ST_START);
    assign dac_set      = (state_q == ST_WRITE);
    assign dac_data     = data_q;
    assign sample_count = cnt_q;
    assign overrun      = ovr_q;
    assign timeout      = tmo_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_adc_dac_sequencer.sv
// Bench for adc_dac_sequencer: ADC/DAC environment models plus an event-schedule
// reference that predicts strobe, write and flag cycles from the period rules.
module tb_adc_dac_sequencer;
    import adc_dac_pkg::*;

    localparam int DATA_W  = 12;
    localparam int DIV_W   = 16;
    localparam int TIMEOUT = 1000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  div = 16'd100;
    logic              clr_status = 1'b0;
    logic              adc_valid = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              dac_busy = 1'b0;
    logic              convst, dac_set, overrun, timeout;
    logic [DATA_W-1:0] dac_data;
    logic [15:0]       sample_count;
    seq_state_t        state_dbg;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // environment knobs, written only by the stimulus block
    int k_lat = 1, k_hold = 0, k_dlen = 0, skip_until = 0, clr_at = -1;
    // environment / monitor state, written only by the negedge block
    int conv_seen = 0, busy_until = -1, due = 0;
    logic pend = 1'b0, ovr_prev = 1'b0, tmo_prev = 1'b0;
    logic [DATA_W-1:0] pend_word = '0, prev_data = '0;
    int conv_q[$], set_q[$], chg_q[$], ovr_rise_q[$], tmo_rise_q[$];
    logic [DATA_W-1:0] setd_q[$];
    // reference expectations
    int e_conv[$], e_set[$], e_chg[$], e_drop[$], e_toev[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_last = '0;

    adc_dac_sequencer #(.DATA_W(DATA_W), .DIV_W(DIV_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .div          (div),
        .clr_status   (clr_status),
        .convst       (convst),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .dac_busy     (dac_busy),
        .dac_set      (dac_set),
        .dac_data     (dac_data),
        .sample_count (sample_count),
        .overrun      (overrun),
        .timeout      (timeout),
        .state_dbg    (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] word_of(input int c);
        return DATA_W'(c * 13 + 32'h5A5);
    endfunction

    // ADC responder, DAC busy model, clear pulse and output monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            adc_valid  = 1'b0;
            pend       = 1'b0;
            dac_busy   = 1'b0;
            clr_status = 1'b0;
            busy_until = -1;
        end else begin
            adc_valid = 1'b0;
            if (pend && cyc == due) begin
                adc_valid = 1'b1;
                adc_data  = pend_word;
                pend      = 1'b0;
                if (cyc + k_hold > busy_until) busy_until = cyc + k_hold;
            end else begin
                adc_data = DATA_W'($urandom);
            end
            if (convst) begin
                if (conv_seen >= skip_until) begin
                    pend      = 1'b1;
                    due       = cyc + k_lat;
                    pend_word = word_of(cyc);
                end
                conv_seen++;
            end
            if (dac_set && cyc + k_dlen > busy_until) busy_until = cyc + k_dlen;
            dac_busy   = (cyc <= busy_until);
            clr_status = (cyc == clr_at);
        end
        if (convst) conv_q.push_back(cyc);
        if (dac_set) begin
            set_q.push_back(cyc);
            setd_q.push_back(dac_data);
        end
        if (dac_data !== prev_data) begin
            chg_q.push_back(cyc);
            prev_data = dac_data;
        end
        if (overrun && !ovr_prev) ovr_rise_q.push_back(cyc);
        if (timeout && !tmo_prev) tmo_rise_q.push_back(cyc);
        ovr_prev = overrun;
        tmo_prev = timeout;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Schedule model: ticks every eff_div cycles; a tick is accepted only when the
    // previous sample has fully retired, otherwise it is an overrun.
    task automatic model(input int n, input int dv, input int lat, input int hold,
                         input int dlen, input int skip, input int stop);
        int eff, idle, bu, k, c, v, b, s;
        logic [DATA_W-1:0] w, prev;
        e_conv.delete(); e_set.delete(); e_chg.delete(); e_drop.delete();
        e_toev.delete(); exp_q.delete();
        eff  = (dv < 2) ? 2 : dv;
        idle = n;
        bu   = -1;
        k    = 0;
        prev = exp_last;
        for (int t = n + eff - 1; t < stop; t += eff) begin
            if (t < idle) begin
                e_drop.push_back(t);
                continue;
            end
            c = t + 1;
            e_conv.push_back(c);
            if (k < skip) begin
                k++;
                e_toev.push_back(c + TIMEOUT);
                idle = c + TIMEOUT + 1;
                continue;
            end
            k++;
            v = c + lat;
            w = word_of(c);
            if (w != prev) e_chg.push_back(v + 1);
            prev = w;
            if (v + hold > bu) bu = v + hold;
            b = (v + 1 > bu + 1) ? v + 1 : bu + 1;
            s = b + 1;
            e_set.push_back(s);
            exp_q.push_back(w);
            if (s + dlen > bu) bu = s + dlen;
            idle = s + 1;
        end
        exp_last = prev;
    endtask

    task automatic run_scenario(input string name, input int dv, input int lat, input int hold,
                                input int dlen, input int skip, input int run_len, input bit clr_last);
        int n, stop, cl, m, cnt_exp;
        int bc, bs, bch, bor, btr;
        bit ovr_exp, tmo_exp;
        @(posedge clk); #1;
        div = DIV_W'(dv); k_lat = lat; k_hold = hold; k_dlen = dlen;
        skip_until = conv_seen + skip;
        clr_at = cyc;
        @(posedge clk); #1;
        check({name, ".pre_overrun"}, 32'(overrun), 0);
        check({name, ".pre_timeout"}, 32'(timeout), 0);
        check({name, ".pre_count"}, 32'(sample_count), 0);
        bc = conv_q.size(); bs = set_q.size(); bch = chg_q.size();
        bor = ovr_rise_q.size(); btr = tmo_rise_q.size();
        clr_at = -1;
        @(negedge clk);
        enable = 1'b1;
        n = cyc;
        stop = n + run_len;
        model(n, dv, lat, hold, dlen, skip, stop);
        if (clr_last && e_set.size() > 0) clr_at = e_set[e_set.size() - 1];
        cl = clr_at;
        repeat (run_len) @(negedge clk);
        enable = 1'b0;
        repeat ((skip > 0) ? 1200 : 300) @(posedge clk);
        #1;

        check({name, ".n_convst"}, conv_q.size() - bc, e_conv.size());
        m = (conv_q.size() - bc < e_conv.size()) ? conv_q.size() - bc : e_conv.size();
        for (int i = 0; i < m; i++) check($sformatf("%s.convst[%0d]", name, i), conv_q[bc + i], e_conv[i]);
        check({name, ".n_dac_set"}, set_q.size() - bs, e_set.size());
        m = (set_q.size() - bs < e_set.size()) ? set_q.size() - bs : e_set.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s.dac_set[%0d]", name, i), set_q[bs + i], e_set[i]);
            check($sformatf("%s.dac_data[%0d]", name, i), 32'(setd_q[bs + i]), 32'(exp_q[i]));
        end
        check({name, ".n_data_chg"}, chg_q.size() - bch, e_chg.size());
        m = (chg_q.size() - bch < e_chg.size()) ? chg_q.size() - bch : e_chg.size();
        for (int i = 0; i < m; i++) check($sformatf("%s.data_chg[%0d]", name, i), chg_q[bch + i], e_chg[i]);
        check({name, ".overrun_rise"}, (ovr_rise_q.size() > bor) ? ovr_rise_q[bor] : -1,
              (e_drop.size() > 0) ? e_drop[0] + 1 : -1);
        check({name, ".timeout_rise"}, (tmo_rise_q.size() > btr) ? tmo_rise_q[btr] : -1,
              (e_toev.size() > 0) ? e_toev[0] + 1 : -1);
        ovr_exp = 1'b0; tmo_exp = 1'b0; cnt_exp = 0;
        foreach (e_drop[i]) if (e_drop[i] >= cl) ovr_exp = 1'b1;
        foreach (e_toev[i]) if (e_toev[i] >= cl) tmo_exp = 1'b1;
        foreach (e_set[i])  if (e_set[i] >= cl) cnt_exp++;
        check({name, ".overrun"}, 32'(overrun), 32'(ovr_exp));
        check({name, ".timeout"}, 32'(timeout), 32'(tmo_exp));
        check({name, ".sample_count"}, 32'(sample_count), cnt_exp);
        check({name, ".state_idle"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    initial begin
        int n, tgt, bc, bs;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.convst", 32'(convst), 0);
        check("rst.dac_set", 32'(dac_set), 0);
        check("rst.dac_data", 32'(dac_data), 0);
        check("rst.sample_count", 32'(sample_count), 0);
        check("rst.overrun", 32'(overrun), 0);
        check("rst.timeout", 32'(timeout), 0);
        check("rst.state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // directed scenarios
        run_scenario("basic",    100, 20, 0,  0, 0, 500,  1'b0);
        run_scenario("backpres", 100, 20, 30, 5, 0, 300,  1'b0);
        run_scenario("timeout", 1100, 20, 0,  0, 1, 2300, 1'b0);
        run_scenario("ovr_clr",   10, 50, 0,  0, 0, 150,  1'b1);
        run_scenario("clamp0",     0,  1, 0,  0, 0, 40,   1'b0);
        run_scenario("clamp1",     1,  1, 0,  0, 0, 40,   1'b0);

        // randomized scenarios
        for (int r = 0; r < 4; r++) begin
            run_scenario($sformatf("rand%0d", r),
                         int'($urandom_range(30, 120)), int'($urandom_range(1, 25)),
                         int'($urandom_range(0, 15)), int'($urandom_range(0, 20)), 0,
                         int'($urandom_range(200, 500)), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset while waiting on a busy DAC
        @(posedge clk); #1;
        div = 16'd100; k_lat = 5; k_hold = 50; k_dlen = 0; skip_until = conv_seen; clr_at = -1;
        @(negedge clk);
        enable = 1'b1;
        n = cyc;
        tgt = n + 100 + 5 + 10;
        while (cyc < tgt) @(negedge clk);
        check("rstmid.state_wait", 32'(state_dbg), 32'(ST_WAIT_DAC));
        rst_n = 1'b0;
        #1;
        check("rstmid.convst", 32'(convst), 0);
        check("rstmid.dac_set", 32'(dac_set), 0);
        check("rstmid.dac_data", 32'(dac_data), 0);
        check("rstmid.sample_count", 32'(sample_count), 0);
        check("rstmid.overrun", 32'(overrun), 0);
        check("rstmid.timeout", 32'(timeout), 0);
        check("rstmid.state", 32'(state_dbg), 32'(ST_IDLE));
        enable = 1'b0;
        exp_last = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bc = conv_q.size();
        bs = set_q.size();
        repeat (100) @(posedge clk);
        #1;
        check("rstmid.no_convst", conv_q.size() - bc, 0);
        check("rstmid.no_dac_set", set_q.size() - bs, 0);
        check("rstmid.count_after", 32'(sample_count), 0);
        check("rstmid.state_after", 32'(state_dbg), 32'(ST_IDLE));

        // fresh run after reset restarts cleanly
        run_scenario("post_rst", 60, 10, 5, 5, 0, 300, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
